// File: rtl/inv_bank_pkg.sv
// Shared constants and helpers for the clocked inverter bank.
package inv_bank_pkg;

  localparam int MODE_TRANSPORT = 0;
  localparam int MODE_INERTIAL  = 1;

  // Constant-foldable ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/inv_bank_chan.sv
// Single-channel delay cell: q is the last delay stage, one edge ahead of the
// bank's registered out, so the top can see an output change before it lands.
module inv_bank_chan
  import inv_bank_pkg::*;
#(
  parameter int   DELAY  = 3,
  parameter int   MODE   = MODE_TRANSPORT,
  parameter logic INIT_V = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (MODE == MODE_INERTIAL) begin : g_inertial
      localparam int CW = clog2(DELAY + 1);

      logic          pending;
      logic [CW-1:0] cnt;
      logic          filt;
      logic          pending_nxt;
      logic [CW-1:0] cnt_nxt;
      logic          filt_nxt;
      logic [CW-1:0] remaining;

      // remaining = further matching samples needed after this one before commit
      always_comb begin
        pending_nxt = 1'b0;
        cnt_nxt     = '0;
        filt_nxt    = filt;
        remaining   = pending ? cnt : CW'(DELAY - 1);
        if (d != filt) begin
          if (remaining == '0) begin
            filt_nxt = d;
          end else begin
            pending_nxt = 1'b1;
            cnt_nxt     = remaining - CW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending <= 1'b0;
          cnt     <= '0;
          filt    <= INIT_V;
        end else begin
          pending <= pending_nxt;
          cnt     <= cnt_nxt;
          filt    <= filt_nxt;
        end
      end

      assign q = filt;
    end else begin : g_transport
      logic [DELAY-1:0] sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= {DELAY{INIT_V}};
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/inv_bank_sync.sv
// WIDTH-channel delayed inverter bank; every change of the output vector is
// queued as one event for the analog-sync bridge.
module inv_bank_sync
  import inv_bank_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DELAY      = 3,
  parameter int MODE       = 0,
  parameter int INVERT     = 1,
  parameter int INIT_V     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             sync_valid,
  output logic [WIDTH-1:0] sync_data,
  input  logic             sync_ready,
  output logic             sync_ovf,
  input  logic             ovf_clr
);

  localparam int   AW       = clog2(FIFO_DEPTH);
  localparam int   PW       = AW + 1;
  localparam logic INIT_BIT = (INIT_V != 0);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  assign d = (INVERT != 0) ? ~in : in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      inv_bank_chan #(
        .DELAY  (DELAY),
        .MODE   (MODE),
        .INIT_V (INIT_BIT)
      ) u_chan (
        .clk (clk),
        .rst (rst),
        .d   (d[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= {WIDTH{INIT_BIT}};
    else     out <= q;
  end

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             pop;
  logic             push;
  logic             drop;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign full       = (count == PW'(FIFO_DEPTH));
  assign push_req   = (q != out);
  assign sync_valid = !empty;
  assign sync_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop        = sync_valid && sync_ready;
  // A pop frees the slot this same edge, so a full FIFO can still accept.
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sync_ovf <= 1'b0;
    else if (drop)    sync_ovf <= 1'b1;
    else if (ovf_clr) sync_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_inv_bank_sync.sv
// Bench for inv_bank_sync: a transport and an inertial instance share inputs,
// checked every cycle against a window/queue model plus directed literals.
module tb_inv_bank_sync;

  localparam int DLY   = 3;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] in_vec;
  logic [3:0] out_tr, out_in;
  logic       valid_tr, valid_in;
  logic [3:0] data_tr, data_in;
  logic       ready_tr, ready_in;
  logic       ovf_tr, ovf_in;
  logic       clr_tr, clr_in;

  int checks;
  int failures;
  logic cmp_en;

  inv_bank_sync #(
    .WIDTH(4), .DELAY(DLY), .MODE(0), .INVERT(1), .INIT_V(0), .FIFO_DEPTH(DEPTH)
  ) u_tr (
    .clk(clk), .rst(rst), .in(in_vec), .out(out_tr),
    .sync_valid(valid_tr), .sync_data(data_tr), .sync_ready(ready_tr),
    .sync_ovf(ovf_tr), .ovf_clr(clr_tr)
  );

  inv_bank_sync #(
    .WIDTH(4), .DELAY(DLY), .MODE(1), .INVERT(1), .INIT_V(0), .FIFO_DEPTH(DEPTH)
  ) u_in (
    .clk(clk), .rst(rst), .in(in_vec), .out(out_in),
    .sync_valid(valid_in), .sync_data(data_in), .sync_ready(ready_in),
    .sync_ovf(ovf_in), .ovf_clr(clr_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: history of effective inputs, expected outputs and event queues.
  logic [3:0] hist [0:DLY];
  logic [3:0] m_out_tr, m_out_in;
  logic [3:0] qtr[$];
  logic [3:0] qin[$];
  logic       m_ovf_tr, m_ovf_in;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task modelReset();
    for (int j = 0; j <= DLY; j++) hist[j] = 4'h0;
    m_out_tr = 4'h0;
    m_out_in = 4'h0;
    qtr.delete();
    qin.delete();
    m_ovf_tr = 1'b0;
    m_ovf_in = 1'b0;
  endtask

  task modelStep();
    logic [3:0] nt, ni;
    logic same, drop;
    for (int j = DLY; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ~in_vec;
    // Transport: value sampled DLY edges ago. Inertial: last DLY samples agree.
    nt = hist[DLY];
    ni = m_out_in;
    for (int b = 0; b < 4; b++) begin
      same = 1'b1;
      for (int j = 2; j <= DLY; j++) if (hist[j][b] != hist[1][b]) same = 1'b0;
      if (same) ni[b] = hist[1][b];
    end
    if (ready_tr && qtr.size() > 0) void'(qtr.pop_front());
    drop = 1'b0;
    if (nt != m_out_tr) begin
      if (qtr.size() < DEPTH) qtr.push_back(nt);
      else drop = 1'b1;
    end
    if (drop) m_ovf_tr = 1'b1;
    else if (clr_tr) m_ovf_tr = 1'b0;
    m_out_tr = nt;
    if (ready_in && qin.size() > 0) void'(qin.pop_front());
    drop = 1'b0;
    if (ni != m_out_in) begin
      if (qin.size() < DEPTH) qin.push_back(ni);
      else drop = 1'b1;
    end
    if (drop) m_ovf_in = 1'b1;
    else if (clr_in) m_ovf_in = 1'b0;
    m_out_in = ni;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("tr_out", out_tr, m_out_tr);
        checkOutput("tr_valid", {3'b0, valid_tr}, {3'b0, qtr.size() > 0});
        checkOutput("tr_data", data_tr, (qtr.size() > 0) ? qtr[0] : 4'h0);
        checkOutput("tr_ovf", {3'b0, ovf_tr}, {3'b0, m_ovf_tr});
        checkOutput("in_out", out_in, m_out_in);
        checkOutput("in_valid", {3'b0, valid_in}, {3'b0, qin.size() > 0});
        checkOutput("in_data", data_in, (qin.size() > 0) ? qin[0] : 4'h0);
        checkOutput("in_ovf", {3'b0, ovf_in}, {3'b0, m_ovf_in});
      end
    end
  end

  task applyStimulus(input logic [3:0] v, input logic r_tr, input logic r_in, input logic c);
    in_vec   = v;
    ready_tr = r_tr;
    ready_in = r_in;
    clr_tr   = c;
    clr_in   = c;
  endtask

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task checkReset(input string tag);
    checkOutput({tag, "_out_tr"}, out_tr, 4'h0);
    checkOutput({tag, "_out_in"}, out_in, 4'h0);
    checkOutput({tag, "_valid"}, {2'b0, valid_tr, valid_in}, 4'h0);
    checkOutput({tag, "_ovf"}, {2'b0, ovf_tr, ovf_in}, 4'h0);
    checkOutput({tag, "_data"}, data_tr | data_in, 4'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] cur;
    logic [3:0] drain_exp [4];
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkReset("por");
    cmp_en = 1'b1;
    rst = 1'b0;
    tick(6);
    checkReset("release");

    // Baseline: all inputs low, outputs settle to 1111 and drain.
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0);
    tick(8);
    checkOutput("base_out", out_tr, 4'hF);
    checkOutput("base_valid", {3'b0, valid_tr}, 4'h0);

    // 1-cycle pulse on in[0] sampled at edge S.
    $display("[TB] transport 1-cycle pulse");
    applyStimulus(4'h1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("pulse_s2", out_tr, 4'hF);
    tick(1);
    checkOutput("pulse_s3", out_tr, 4'hE);
    tick(1);
    checkOutput("pulse_s4", out_tr, 4'hF);
    checkOutput("pulse_head1", data_tr, 4'hE);
    checkOutput("pulse_in_out", out_in, 4'hF);
    checkOutput("pulse_in_valid", {3'b0, valid_in}, 4'h0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("pulse_head2", data_tr, 4'hF);
    tick(1);
    checkOutput("pulse_empty", {3'b0, valid_tr}, 4'h0);

    $display("[TB] inertial glitch and propagation");
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b0);
    tick(2);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    tick(6);
    checkOutput("glitch_out", out_in, 4'hF);
    checkOutput("glitch_valid", {3'b0, valid_in}, 4'h0);
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("prop_s2", out_in, 4'hF);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("prop_s3", out_in, 4'hD);
    tick(2);
    checkOutput("prop_s5", out_in, 4'hD);
    tick(1);
    checkOutput("prop_s6", out_in, 4'hF);
    checkOutput("prop_head1", data_in, 4'hD);
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("prop_head2", data_in, 4'hF);
    tick(1);
    checkOutput("prop_empty", {3'b0, valid_in}, 4'h0);

    $display("[TB] simultaneous channels");
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("simul_out", out_tr | out_in, 4'h0);
    checkOutput("simul_valid", {2'b0, valid_tr, valid_in}, 4'h3);
    applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("simul_one", {2'b0, valid_tr, valid_in}, 4'h0);

    $display("[TB] overflow and clear");
    cur = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cur = cur ^ 4'h4;
      applyStimulus(cur, 1'b0, 1'b0, 1'b0);
      tick(4);
    end
    checkOutput("ovf_set", {2'b0, ovf_tr, ovf_in}, 4'h3);
    checkOutput("ovf_head", data_tr, 4'h4);
    cur = cur ^ 4'h4;
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(cur, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set_wins", {2'b0, ovf_tr, ovf_in}, 4'h3);
    applyStimulus(cur, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", {2'b0, ovf_tr, ovf_in}, 4'h0);
    checkOutput("ovf_head_kept", data_in, 4'h4);

    $display("[TB] full with push and pop");
    cur = cur ^ 4'h4;
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(cur, 1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    checkOutput("pp_ovf", {2'b0, ovf_tr, ovf_in}, 4'h0);
    drain_exp[0] = 4'h0;
    drain_exp[1] = 4'h4;
    drain_exp[2] = 4'h0;
    drain_exp[3] = 4'h4;
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp_valid", {2'b0, valid_tr, valid_in}, 4'h3);
      checkOutput("pp_data_tr", data_tr, drain_exp[i]);
      checkOutput("pp_data_in", data_in, drain_exp[i]);
      applyStimulus(cur, 1'b1, 1'b1, 1'b0);
      tick(1);
      applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("pp_empty", {2'b0, valid_tr, valid_in}, 4'h0);

    $display("[TB] mid-run reset");
    for (int i = 0; i < 5; i++) begin
      cur = cur ^ 4'h1;
      applyStimulus(cur, 1'b0, 1'b0, 1'b0);
      tick(4);
    end
    checkOutput("pre_rst_out", out_tr, 4'h5);
    checkOutput("pre_rst_ovf", {2'b0, ovf_tr, ovf_in}, 4'h3);
    #1;
    rst = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    #1;
    checkReset("async");
    tick(2);
    rst = 1'b0;
    tick(8);
    checkReset("rerelease");

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
